// File: rtl/mem_stage_if.sv
// Bundle interface between the ALU (master) and the memory/writeback stage (slave).
// Carries the ALU result bundle, the register-file writeback port and stage status.
interface mem_stage_if;
    logic        inValid;
    logic        inReady;
    logic [31:0] dataIn1;
    logic [31:0] dataIn2;
    logic [31:0] cpsrIn;
    logic        wIn;
    logic        mIn;
    logic [31:0] srcDstIn;
    logic        wbValid;
    logic [3:0]  wbReg;
    logic [31:0] wbData;
    logic [31:0] cpsrOut;
    logic        storeDone;
    logic        memFault;
    logic        busy;

    modport master (
        output inValid, dataIn1, dataIn2, cpsrIn, wIn, mIn, srcDstIn,
        input  inReady, wbValid, wbReg, wbData, cpsrOut, storeDone, memFault, busy
    );

    modport slave (
        input  inValid, dataIn1, dataIn2, cpsrIn, wIn, mIn, srcDstIn,
        output inReady, wbValid, wbReg, wbData, cpsrOut, storeDone, memFault, busy
    );
endinterface

// File: rtl/mem_stage.sv
// Memory/writeback stage: executes loads/stores against an internal word RAM and
// drives a single register-file writeback port plus the registered CPSR.
module mem_stage #(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8
) (
    input logic       clk,
    input logic       reset,
    mem_stage_if.slave bus
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] EXEC   = 2'd1;
    localparam logic [1:0] RDWAIT = 2'd2;
    localparam logic [1:0] WB     = 2'd3;

    logic [1:0]  state;
    logic        accept;

    logic [31:0] d2_p0;
    logic [31:0] srcdst_p0;
    logic        w_p0;
    logic [31:0] rdata_p1;
    logic [31:0] ram [DEPTH];

    logic [31:0] addr;
    logic        in_range;
    logic [ADDR_W-1:0] idx;
    logic        do_store;
    logic        do_load;

    logic        wb_valid;
    logic [3:0]  wb_reg;
    logic [31:0] wb_data;
    logic [31:0] cpsr;
    logic        store_done;

    assign accept = bus.inValid && (state == IDLE);

    // Captured bundle (accept edge); only memory ops read it back later
    always_ff @(posedge clk) begin
        if (accept) begin
            d2_p0     <= bus.dataIn2;
            srcdst_p0 <= bus.srcDstIn;
            w_p0      <= bus.wIn;
        end
    end

    always_comb begin
        addr     = w_p0 ? d2_p0 : srcdst_p0;
        in_range = (addr < 32'(DEPTH));
        idx      = addr[ADDR_W-1:0];
        do_store = (state == EXEC) && !w_p0 && in_range;
        do_load  = (state == EXEC) &&  w_p0 && in_range;
    end

    // RAM access (EXEC edge); contents survive reset
    always_ff @(posedge clk) begin
        if (do_store) begin
            ram[idx] <= d2_p0;
        end
        if (do_load) begin
            rdata_p1 <= ram[idx];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            wb_valid   <= 1'b0;
            wb_reg     <= 4'd0;
            wb_data    <= 32'd0;
            cpsr       <= 32'd0;
            store_done <= 1'b0;
        end else begin
            wb_valid   <= 1'b0;
            store_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        cpsr <= bus.cpsrIn;
                        if (bus.mIn) begin
                            state <= EXEC;
                        end else if (bus.wIn) begin
                            state    <= WB;
                            wb_valid <= 1'b1;
                            wb_reg   <= bus.srcDstIn[3:0];
                            wb_data  <= bus.dataIn1;
                        end
                    end
                end
                EXEC: begin
                    if (w_p0) begin
                        if (in_range) begin
                            state <= RDWAIT;
                        end else begin
                            // Faulting load still retires with a zero writeback
                            state    <= WB;
                            wb_valid <= 1'b1;
                            wb_reg   <= srcdst_p0[3:0];
                            wb_data  <= 32'd0;
                        end
                    end else begin
                        store_done <= in_range;
                        state      <= IDLE;
                    end
                end
                RDWAIT: begin
                    state    <= WB;
                    wb_valid <= 1'b1;
                    wb_reg   <= srcdst_p0[3:0];
                    wb_data  <= rdata_p1;
                end
                WB: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Fault is flagged during EXEC so it never coincides with the zero writeback
    assign bus.memFault  = (state == EXEC) && !in_range;
    assign bus.inReady   = (state == IDLE);
    assign bus.busy      = (state != IDLE);
    assign bus.wbValid   = wb_valid;
    assign bus.wbReg     = wb_reg;
    assign bus.wbData    = wb_data;
    assign bus.cpsrOut   = cpsr;
    assign bus.storeDone = store_done;
endmodule
